genie_unconv: RTL

GENIE_UNCONV -- requirements
Module: genie_unconv

---
 rtl/genie_pkg.sv | 13 +
 rtl/genie_unconv_lookup.sv | 29 ++
 rtl/genie_unconv.sv | 121 ++++++++++++
 3 files changed

// File: rtl/genie_pkg.sv
// Shared types for the genie field-conversion blocks: output buffer occupancy
// states and the width of the saturating miss counter.
package genie_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    localparam int MISS_CNT_W = 16;

endpackage

// File: rtl/genie_unconv_lookup.sv
// Inverts the conversion table: finds key among OUT_VALS, returns matching IN_VALS.
// Purely combinational, zero latency, no flow control.
module genie_unconv_lookup
    import genie_pkg::*;
#(
    parameter int WIDTH_IN  = 0,
    parameter int WIDTH_OUT = 0,
    parameter int N_ENTRIES = 0,
    parameter logic [N_ENTRIES-1:0][WIDTH_OUT-1:0] IN_VALS  = '0,
    parameter logic [N_ENTRIES-1:0][WIDTH_IN-1:0]  OUT_VALS = '0
) (
    input  logic [WIDTH_IN-1:0]  key,
    output logic [WIDTH_OUT-1:0] field,
    output logic                 miss
);

    // Scan from the top index down so the lowest matching entry overrides the rest.
    always_comb begin
        field = '0;
        miss  = 1'b1;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (key == OUT_VALS[i]) begin
                field = IN_VALS[i];
                miss  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/genie_unconv.sv
// Recovers the original field from a converted one; 1-cycle latency, 1 beat/cycle.
// Main + skid register keep o_ready a pure register output; o_ready drops only when both hold beats.
module genie_unconv
    import genie_pkg::*;
#(
    parameter int WIDTH_DATA = 0,
    parameter int WIDTH_IN   = 0,
    parameter int WIDTH_OUT  = 0,
    parameter int N_ENTRIES  = 0,
    parameter logic [N_ENTRIES-1:0][WIDTH_OUT-1:0] IN_VALS  = '0,
    parameter logic [N_ENTRIES-1:0][WIDTH_IN-1:0]  OUT_VALS = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH_DATA-1:0] i_data,
    input  logic [WIDTH_IN-1:0]   i_field,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [WIDTH_DATA-1:0] o_data,
    output logic [WIDTH_OUT-1:0]  o_field,
    output logic                  o_miss,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_err,
    output logic [MISS_CNT_W-1:0] o_miss_count
);

    buf_state_t             state;
    logic [WIDTH_DATA-1:0]  skid_data;
    logic [WIDTH_OUT-1:0]   skid_field;
    logic                   skid_miss;
    logic [WIDTH_OUT-1:0]   lk_field;
    logic                   lk_miss;
    logic                   accept;
    logic                   xfer;

    assign accept = i_valid && o_ready;
    assign xfer   = o_valid && i_ready;

    genie_unconv_lookup #(
        .WIDTH_IN  (WIDTH_IN),
        .WIDTH_OUT (WIDTH_OUT),
        .N_ENTRIES (N_ENTRIES),
        .IN_VALS   (IN_VALS),
        .OUT_VALS  (OUT_VALS)
    ) u_lookup (
        .key   (i_field),
        .field (lk_field),
        .miss  (lk_miss)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= EMPTY;
            o_valid      <= 1'b0;
            o_ready      <= 1'b1;
            o_data       <= '0;
            o_field      <= '0;
            o_miss       <= 1'b0;
            skid_data    <= '0;
            skid_field   <= '0;
            skid_miss    <= 1'b0;
            o_err        <= 1'b0;
            o_miss_count <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        o_data  <= i_data;
                        o_field <= lk_field;
                        o_miss  <= lk_miss;
                        o_valid <= 1'b1;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    if (accept && xfer) begin
                        o_data  <= i_data;
                        o_field <= lk_field;
                        o_miss  <= lk_miss;
                    end else if (accept) begin
                        // Downstream stalled: park the new beat, close the input.
                        skid_data  <= i_data;
                        skid_field <= lk_field;
                        skid_miss  <= lk_miss;
                        o_ready    <= 1'b0;
                        state      <= FULL;
                    end else if (xfer) begin
                        o_valid <= 1'b0;
                        state   <= EMPTY;
                    end
                end
                FULL: begin
                    if (xfer) begin
                        o_data  <= skid_data;
                        o_field <= skid_field;
                        o_miss  <= skid_miss;
                        o_ready <= 1'b1;
                        state   <= ONE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= EMPTY;
                end
            endcase

            if (accept && lk_miss) begin
                o_err <= 1'b1;
                if (o_miss_count != '1) begin
                    o_miss_count <= o_miss_count + MISS_CNT_W'(1);
                end
            end
        end
    end

    a_miss_flagged : assert property (@(posedge clk) disable iff (reset)
        (accept && lk_miss) |=> o_err);

endmodule
